ice_sl_bus_reader: RTL and testbench

Drains the ICE slave output bus, the consumer side of the `sl_*` interface that MBus and the other ICE protocol blocks write received frames into. Each source keeps its own 512-entry ring of 9-bit words (bit 8 = end-of-frame). The reader arbitrates between requesting sources, walks the granted ring from its private head pointer to the terminator, and streams bytes to the host-side byte channel. It then hands the freed space back to the source via `sl_latch_tail`.

---
 rtl/ice_bus_pkg.sv | 18 +
 rtl/ice_rr_arbiter.sv | 47 ++++
 rtl/ice_sl_bus_reader.sv | 177 +++++++++++++++++
 tb/tb_ice_sl_bus_reader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_bus_pkg.sv
// Shared definitions for the ICE slave output bus: word layout and reader FSM states.
package ice_bus_pkg;

  localparam int SL_AW      = 9;
  localparam int SL_DW      = 9;
  localparam int SL_EOF_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ADDR,
    DATA,
    LATCH,
    ABORT,
    RELEASE
  } sl_rd_state_t;

endpackage

// File: rtl/ice_rr_arbiter.sv
// Round-robin source picker. The search starts just after the last-served source;
// 'advance' records the served index once its frame is finished or aborted.
module ice_rr_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req,
  input  logic                       advance,
  input  logic [$clog2(NUM_SRC)-1:0] served,
  output logic                       any,
  output logic [$clog2(NUM_SRC)-1:0] pick
);

  localparam int IW = $clog2(NUM_SRC);

  logic [IW-1:0]          last_q, last_d;
  logic [2*NUM_SRC-1:0]   req2;
  logic [NUM_SRC-1:0]     rot;
  logic                   found;
  int                     sum;

  // Rotate requests so bit 0 is the source after last_q, then take the lowest set bit.
  always_comb begin
    req2  = {req, req};
    rot   = NUM_SRC'(req2 >> (int'(last_q) + 1));
    any   = |rot;
    found = 1'b0;
    sum   = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = int'(last_q) + 1 + j;
      end
    end
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    pick   = IW'(sum);
    last_d = advance ? served : last_q;
  end

  // Last-served register; resets to the top index so source 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= IW'(NUM_SRC - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ice_sl_bus_reader.sv
// Slave-bus reader: arbitrates sources, walks the granted ring from its head pointer
// to the end-of-frame word, streams bytes to the host and returns freed space.
module ice_sl_bus_reader
  import ice_bus_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int RD_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         sl_arb_request,
  output logic [NUM_SRC-1:0]         sl_arb_grant,
  output logic [SL_AW-1:0]           sl_addr,
  input  logic [SL_DW*NUM_SRC-1:0]   sl_data_i,
  input  logic [SL_AW*NUM_SRC-1:0]   sl_tail_i,
  output logic                       sl_latch_tail,
  output logic [7:0]                 out_data,
  output logic [$clog2(NUM_SRC)-1:0] out_src,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       out_err,
  input  logic                       out_ready
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int LW = 2;

  sl_rd_state_t       state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SL_AW-1:0]   addr_q, addr_d;
  logic               latch_q, latch_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [IW-1:0]      src_q, src_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [SL_AW-1:0]   head_q [NUM_SRC];
  logic [SL_AW-1:0]   head_d [NUM_SRC];

  logic [SL_DW-1:0]   rd_word [NUM_SRC];
  logic [SL_AW-1:0]   tail_w  [NUM_SRC];
  logic [SL_AW-1:0]   cur_head, cur_tail;
  logic [SL_DW-1:0]   cur_word;
  logic               arb_any, advance;
  logic [IW-1:0]      arb_pick;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_split
    assign rd_word[gi] = sl_data_i[gi*SL_DW +: SL_DW];
    assign tail_w[gi]  = sl_tail_i[gi*SL_AW +: SL_AW];
  end

  ice_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (sl_arb_request),
    .advance (advance),
    .served  (src_q),
    .any     (arb_any),
    .pick    (arb_pick)
  );

  // Next-state and registered-output computation for the frame walker.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    latch_d  = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    last_d   = last_q;
    valid_d  = valid_q;
    src_d    = src_q;
    lat_d    = lat_q;
    head_d   = head_q;
    advance  = 1'b0;
    cur_head = head_q[src_q];
    cur_tail = tail_w[src_q];
    cur_word = rd_word[src_q];
    case (state_q)
      // RELEASE can arbitrate directly so consecutive frames see a single idle-grant cycle.
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (arb_any) begin
          src_d   = arb_pick;
          grant_d = NUM_SRC'(1) << arb_pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        addr_d  = cur_head;
        lat_d   = '0;
        state_d = ADDR;
      end
      ADDR: begin
        if (lat_q == '0 && addr_q == cur_tail) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end else if (lat_q == LW'(RD_LAT - 1)) begin
          data_d  = cur_word[7:0];
          last_d  = cur_word[SL_EOF_BIT];
          valid_d = 1'b1;
          state_d = DATA;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      DATA: begin
        if (out_ready) begin
          valid_d        = 1'b0;
          last_d         = 1'b0;
          head_d[src_q]  = cur_head + SL_AW'(1);
          if (last_q) begin
            addr_d  = cur_head + SL_AW'(1);
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            addr_d  = addr_q + SL_AW'(1);
            lat_d   = '0;
            state_d = ADDR;
          end
        end
      end
      LATCH: begin
        advance = 1'b1;
        grant_d = '0;
        state_d = RELEASE;
      end
      ABORT: begin
        advance       = 1'b1;
        head_d[src_q] = cur_tail;
        grant_d       = '0;
        state_d       = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, head pointers and all outputs are registered; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      latch_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
      lat_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) head_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      latch_q <= latch_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      src_q   <= src_d;
      lat_q   <= lat_d;
      head_q  <= head_d;
    end
  end

  assign sl_arb_grant  = grant_q;
  assign sl_addr       = addr_q;
  assign sl_latch_tail = latch_q;
  assign out_data      = data_q;
  assign out_src       = src_q;
  assign out_valid     = valid_q;
  assign out_last      = last_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_ice_sl_bus_reader.sv
// Bench for ice_sl_bus_reader: ring memories per source, scoreboard of expected bytes.
module tb_ice_sl_bus_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  sl_arb_request = 2'b00;
  logic [1:0]  sl_arb_grant;
  logic [8:0]  sl_addr;
  logic [17:0] sl_data_i;
  logic [17:0] sl_tail_i;
  logic        sl_latch_tail;
  logic [7:0]  out_data;
  logic [0:0]  out_src;
  logic        out_valid;
  logic        out_last;
  logic        out_err;
  logic        out_ready = 1'b1;

  logic [8:0]  mem0 [512];
  logic [8:0]  mem1 [512];
  logic [8:0]  tail0 = 9'd0;
  logic [8:0]  tail1 = 9'd0;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  sb [$];
  logic [9:0]  mon_exp;
  logic [8:0]  addr_log [$];
  int          hs_count = 0;
  int          latch_count = 0;
  int          err_count = 0;
  logic [8:0]  latch_addr = 9'd0;

  always #5 clk = ~clk;

  assign sl_data_i = {mem1[sl_addr], mem0[sl_addr]};
  assign sl_tail_i = {tail1, tail0};

  ice_sl_bus_reader #(.NUM_SRC(2), .RD_LAT(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .sl_arb_request (sl_arb_request),
    .sl_arb_grant   (sl_arb_grant),
    .sl_addr        (sl_addr),
    .sl_data_i      (sl_data_i),
    .sl_tail_i      (sl_tail_i),
    .sl_latch_tail  (sl_latch_tail),
    .out_data       (out_data),
    .out_src        (out_src),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_err        (out_err),
    .out_ready      (out_ready)
  );

  // Monitor: pops the scoreboard on each handshake, tracks latch/err pulses, retires requests.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        hs_count++;
        addr_log.push_back(sl_addr);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got src=%0d last=%0b data=%02h, expected no byte", out_src, out_last, out_data);
        end else begin
          mon_exp = sb.pop_front();
          if ({out_src, out_last, out_data} !== mon_exp) begin
            errors++;
            $display("FAIL sb_byte: got src=%0d last=%0b data=%02h, expected src=%0d last=%0b data=%02h",
                     out_src, out_last, out_data, mon_exp[9], mon_exp[8], mon_exp[7:0]);
          end else begin
            $display("byte src=%0d addr=%0d data=%02h last=%0b", out_src, sl_addr, out_data, out_last);
          end
        end
      end
      if (sl_latch_tail) begin
        latch_count++;
        latch_addr = sl_addr;
        $display("latch src_grant=%b addr=%0d", sl_arb_grant, sl_addr);
        sl_arb_request = sl_arb_request & ~sl_arb_grant;
      end
      if (out_err) begin
        err_count++;
        $display("abort src_grant=%b addr=%0d", sl_arb_grant, sl_addr);
        sl_arb_request = sl_arb_request & ~sl_arb_grant;
      end
    end
  end

  task automatic stage(input logic s, input logic [8:0] a, input logic [7:0] d, input logic l);
    if (s) mem1[a] = {l, d};
    else   mem0[a] = {l, d};
    sb.push_back({s, l, d});
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sl_arb_request == 2'b00 && sb.size() == 0 && sl_arb_grant == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sl_arb_grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", sl_arb_grant); end
    checks++; if (sl_addr !== 9'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", sl_addr); end
    checks++; if (sl_latch_tail !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", sl_latch_tail); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", out_last); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", out_err); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h want 00", out_data); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL rst_src: got %0d want 0", out_src); end
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sl_arb_grant !== 2'b00) begin errors++; $display("FAIL idle_grant: got %b want 00", sl_arb_grant); end
  endtask

  task automatic test_frame_src1;
    logic [7:0] fb [10];
    bit ok;
    int l0;
    fb = '{8'h0a, 8'h08, 8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
    for (int k = 0; k < 10; k++) stage(1'b1, 9'(k), fb[k], k == 9);
    tail1 = 9'd10;
    addr_log.delete();
    l0 = latch_count;
    @(posedge clk); #2;
    sl_arb_request = 2'b10;
    @(posedge clk); #1;
    checks++; if (sl_arb_grant !== 2'b10) begin errors++; $display("FAIL f1_grant: got %b want 10", sl_arb_grant); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL f1_timeout: got done=0 want done=1"); end
    checks++; if (latch_count !== l0 + 1) begin errors++; $display("FAIL f1_latch_cnt: got %0d want %0d", latch_count - l0, 1); end
    checks++; if (latch_addr !== 9'd10) begin errors++; $display("FAIL f1_latch_addr: got %0d want 10", latch_addr); end
    checks++; if (addr_log.size() !== 10) begin errors++; $display("FAIL f1_nbytes: got %0d want 10", addr_log.size()); end
  endtask

  task automatic test_both;
    logic [1:0] glog [$];
    bit ok;
    bit seen01;
    int zeros;
    int gap;
    logic [1:0] first_g;
    for (int k = 0; k < 3; k++) stage(1'b0, 9'(k), 8'(8'ha0 + k), k == 2);
    for (int k = 0; k < 3; k++) stage(1'b1, 9'(10 + k), 8'(8'hb0 + k), k == 2);
    tail0 = 9'd3;
    tail1 = 9'd13;
    @(posedge clk); #2;
    sl_arb_request = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      glog.push_back(sl_arb_grant);
      if (sl_arb_request == 2'b00 && sb.size() == 0 && sl_arb_grant == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL both_timeout: got done=0 want done=1"); end
    seen01 = 1'b0; zeros = 0; gap = -1; first_g = 2'b00;
    foreach (glog[i]) begin
      if (first_g == 2'b00 && glog[i] != 2'b00) first_g = glog[i];
      if (glog[i] == 2'b01) begin seen01 = 1'b1; zeros = 0; end
      else if (glog[i] == 2'b00 && seen01 && gap < 0) zeros++;
      else if (glog[i] == 2'b10 && seen01 && gap < 0) gap = zeros;
    end
    checks++; if (first_g !== 2'b01) begin errors++; $display("FAIL both_first: got %b want 01", first_g); end
    checks++; if (gap !== 1) begin errors++; $display("FAIL both_gap: got %0d want 1", gap); end
  endtask

  task automatic test_abort;
    bit ok;
    int e0, l0;
    stage(1'b0, 9'd3, 8'h11, 1'b0);
    stage(1'b0, 9'd4, 8'h22, 1'b0);
    tail0 = 9'd5;
    e0 = err_count; l0 = latch_count;
    addr_log.delete();
    @(posedge clk); #2;
    sl_arb_request = 2'b01;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ab_timeout: got done=0 want done=1"); end
    checks++; if (err_count !== e0 + 1) begin errors++; $display("FAIL ab_err_cnt: got %0d want 1", err_count - e0); end
    checks++; if (latch_count !== l0) begin errors++; $display("FAIL ab_latch_cnt: got %0d want 0", latch_count - l0); end
    checks++; if (addr_log.size() !== 2) begin errors++; $display("FAIL ab_nbytes: got %0d want 2", addr_log.size()); end
  endtask

  task automatic test_long;
    bit ok;
    for (int a = 13; a <= 509; a++) stage(1'b1, 9'(a), 8'(a) ^ 8'h5a, a == 509);
    tail1 = 9'd510;
    addr_log.delete();
    @(posedge clk); #2;
    sl_arb_request = 2'b10;
    wait_done(1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_timeout: got done=0 want done=1"); end
    checks++; if (addr_log.size() !== 497) begin errors++; $display("FAIL long_nbytes: got %0d want 497", addr_log.size()); end
    checks++; if (addr_log.size() > 0 && addr_log[0] !== 9'd13) begin errors++; $display("FAIL long_start: got %0d want 13", addr_log[0]); end
    checks++; if (latch_addr !== 9'd510) begin errors++; $display("FAIL long_latch: got %0d want 510", latch_addr); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [8:0] want [4];
    want = '{9'd510, 9'd511, 9'd0, 9'd1};
    for (int k = 0; k < 4; k++) stage(1'b1, 9'(510 + k), 8'(8'h70 + k), k == 3);
    tail1 = 9'd2;
    addr_log.delete();
    @(posedge clk); #2;
    sl_arb_request = 2'b10;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got done=0 want done=1"); end
    checks++; if (addr_log.size() !== 4) begin errors++; $display("FAIL wrap_nbytes: got %0d want 4", addr_log.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < addr_log.size()) begin
        checks++;
        if (addr_log[k] !== want[k]) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", k, addr_log[k], want[k]); end
      end
    end
    checks++; if (latch_addr !== 9'd2) begin errors++; $display("FAIL wrap_latch: got %0d want 2", latch_addr); end
  endtask

  task automatic test_stall;
    bit ok;
    bit hit;
    int base;
    for (int k = 0; k < 5; k++) stage(1'b0, 9'(5 + k), 8'(8'hc0 + k), k == 4);
    tail0 = 9'd10;
    addr_log.delete();
    base = hs_count;
    @(posedge clk); #2;
    sl_arb_request = 2'b01;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (hs_count >= base + 2) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL stall_reach: got %0d bytes want 2", hs_count - base); end
    out_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", c, out_valid); end
      checks++; if (out_data !== 8'hc2) begin errors++; $display("FAIL stall_data%0d: got %02h want c2", c, out_data); end
      checks++; if (sl_addr !== 9'd7) begin errors++; $display("FAIL stall_addr%0d: got %0d want 7", c, sl_addr); end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got done=0 want done=1"); end
    checks++; if (addr_log.size() !== 5) begin errors++; $display("FAIL stall_nbytes: got %0d want 5", addr_log.size()); end
    checks++; if (addr_log.size() > 0 && addr_log[0] !== 9'd5) begin errors++; $display("FAIL stall_start: got %0d want 5", addr_log[0]); end
    checks++; if (latch_addr !== 9'd10) begin errors++; $display("FAIL stall_latch: got %0d want 10", latch_addr); end
  endtask

  task automatic test_reset_mid;
    bit hit;
    int base, l0;
    for (int k = 0; k < 8; k++) stage(1'b0, 9'(10 + k), 8'(8'hd0 + k), k == 7);
    tail0 = 9'd18;
    base = hs_count;
    @(posedge clk); #2;
    sl_arb_request = 2'b01;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (hs_count >= base + 3 && out_valid) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmid_reach: got %0d bytes want 3", hs_count - base); end
    l0 = latch_count;
    reset = 1'b0;
    #1;
    checks++; if (sl_arb_grant !== 2'b00) begin errors++; $display("FAIL rmid_grant: got %b want 00", sl_arb_grant); end
    checks++; if (sl_addr !== 9'd0) begin errors++; $display("FAIL rmid_addr: got %0d want 0", sl_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %02h want 00", out_data); end
    checks++; if (sl_latch_tail !== 1'b0) begin errors++; $display("FAIL rmid_latch: got %b want 0", sl_latch_tail); end
    sb.delete();
    sl_arb_request = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    checks++; if (latch_count !== l0) begin errors++; $display("FAIL rmid_latch_cnt: got %0d want 0", latch_count - l0); end
  endtask

  task automatic test_resume;
    bit ok;
    for (int k = 0; k < 3; k++) stage(1'b0, 9'(k), 8'(8'he0 + k), k == 2);
    tail0 = 9'd3;
    addr_log.delete();
    @(posedge clk); #2;
    sl_arb_request = 2'b01;
    @(posedge clk); #1;
    checks++; if (sl_arb_grant !== 2'b01) begin errors++; $display("FAIL res_grant: got %b want 01", sl_arb_grant); end
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL res_timeout: got done=0 want done=1"); end
    checks++; if (addr_log.size() > 0 && addr_log[0] !== 9'd0) begin errors++; $display("FAIL res_start: got %0d want 0", addr_log[0]); end
    checks++; if (latch_addr !== 9'd3) begin errors++; $display("FAIL res_latch: got %0d want 3", latch_addr); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 9'd0;
      mem1[i] = 9'd0;
    end
    test_reset;
    test_frame_src1;
    test_both;
    test_abort;
    test_long;
    test_wrap;
    test_stall;
    test_reset_mid;
    test_resume;
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2ms, want finish");
    $fatal(1, "watchdog");
  end

endmodule
